// File: rtl/oa_addr_serializer.sv
// Serializes a bundle of LANES (row, col, ch) address triples into one element per cycle,
// ascending lane order, with a linearized OA address. Optional range check: OA_BOUNDS_CHECK_EN.
module oa_addr_serializer #(
    parameter int LANES   = 8,
    parameter int ROW_W   = 10,
    parameter int COL_W   = 11,
    parameter int CH_W    = 8,
    parameter int OA_ROWS = 64,
    parameter int OA_COLS = 64,
    parameter int LIN_W   = 24,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*ROW_W-1:0] in_row,
    input  logic [LANES*COL_W-1:0] in_col,
    input  logic [LANES*CH_W-1:0]  in_ch,
    input  logic [LANES-1:0]       in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ROW_W-1:0]       out_row,
    output logic [COL_W-1:0]       out_col,
    output logic [CH_W-1:0]        out_ch,
    output logic [LIN_W-1:0]       out_lin_addr,
    output logic [LANE_W-1:0]      out_lane,
    output logic                   busy,
    output logic [15:0]            drop_count
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             r_state;
    logic [LANES-1:0]   r_pending;
    logic [ROW_W-1:0]   r_row [LANES];
    logic [COL_W-1:0]   r_col [LANES];
    logic [CH_W-1:0]    r_ch  [LANES];
    logic               r_outValid;
    logic [ROW_W-1:0]   r_outRow;
    logic [COL_W-1:0]   r_outCol;
    logic [CH_W-1:0]    r_outCh;
    logic [LIN_W-1:0]   r_outLin;
    logic [LANE_W-1:0]  r_outLane;

    logic [ROW_W-1:0]   w_inRow [LANES];
    logic [COL_W-1:0]   w_inCol [LANES];
    logic [CH_W-1:0]    w_inCh  [LANES];
    logic [LANES-1:0]   w_inRange;
    logic [LANES-1:0]   w_capPending;
    logic [LANE_W-1:0]  w_capLane;
    logic [LANE_W-1:0]  w_emitLane;
    logic [LANE_W-1:0]  w_ldLane;
    logic [ROW_W-1:0]   w_ldRow;
    logic [COL_W-1:0]   w_ldCol;
    logic [CH_W-1:0]    w_ldCh;
    logic [LIN_W-1:0]   w_ldLin;

    function automatic logic [LANE_W-1:0] lowestLane(input logic [LANES-1:0] vec);
        lowestLane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (vec[i]) lowestLane = LANE_W'(i);
        end
    endfunction

    function automatic logic [LIN_W-1:0] linAddr(input logic [CH_W-1:0] ch,
                                                 input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
        linAddr = (LIN_W'(ch) * LIN_W'(OA_ROWS) + LIN_W'(row)) * LIN_W'(OA_COLS) + LIN_W'(col);
    endfunction

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_inRow[i] = in_row[i*ROW_W +: ROW_W];
            w_inCol[i] = in_col[i*COL_W +: COL_W];
            w_inCh[i]  = in_ch[i*CH_W +: CH_W];
`ifdef OA_BOUNDS_CHECK_EN
            w_inRange[i] = (32'(w_inRow[i]) < OA_ROWS) && (32'(w_inCol[i]) < OA_COLS);
`else
            w_inRange[i] = 1'b1;
`endif
        end
    end

    assign w_capPending = in_mask & w_inRange;
    assign w_capLane    = lowestLane(w_capPending);
    assign w_emitLane   = lowestLane(r_pending);

    // In IDLE the first element comes straight from the inputs; in EMIT from the captured bundle.
    assign w_ldLane = (r_state == IDLE) ? w_capLane : w_emitLane;
    assign w_ldRow  = (r_state == IDLE) ? w_inRow[w_capLane] : r_row[w_emitLane];
    assign w_ldCol  = (r_state == IDLE) ? w_inCol[w_capLane] : r_col[w_emitLane];
    assign w_ldCh   = (r_state == IDLE) ? w_inCh[w_capLane]  : r_ch[w_emitLane];
    assign w_ldLin  = linAddr(w_ldCh, w_ldRow, w_ldCol);

`ifdef OA_BOUNDS_CHECK_EN
    logic [15:0]      r_dropCount;
    logic [LANES-1:0] w_dropVec;
    logic [16:0]      w_dropSum;
    logic [15:0]      w_dropNext;

    assign w_dropVec  = in_mask & ~w_inRange;
    assign w_dropSum  = {1'b0, r_dropCount} + 17'($countones(w_dropVec));
    assign w_dropNext = w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
    assign drop_count = r_dropCount;
`else
    assign drop_count = 16'd0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_outValid <= 1'b0;
            r_outRow   <= '0;
            r_outCol   <= '0;
            r_outCh    <= '0;
            r_outLin   <= '0;
            r_outLane  <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_row[i] <= '0;
                r_col[i] <= '0;
                r_ch[i]  <= '0;
            end
`ifdef OA_BOUNDS_CHECK_EN
            r_dropCount <= 16'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < LANES; i++) begin
                            r_row[i] <= w_inRow[i];
                            r_col[i] <= w_inCol[i];
                            r_ch[i]  <= w_inCh[i];
                        end
`ifdef OA_BOUNDS_CHECK_EN
                        r_dropCount <= w_dropNext;
`endif
                        if (|w_capPending) begin
                            r_outRow   <= w_ldRow;
                            r_outCol   <= w_ldCol;
                            r_outCh    <= w_ldCh;
                            r_outLin   <= w_ldLin;
                            r_outLane  <= w_ldLane;
                            r_pending  <= w_capPending & ~(LANES'(1) << w_capLane);
                            r_outValid <= 1'b1;
                            r_state    <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (|r_pending) begin
                            r_outRow  <= w_ldRow;
                            r_outCol  <= w_ldCol;
                            r_outCh   <= w_ldCh;
                            r_outLin  <= w_ldLin;
                            r_outLane <= w_ldLane;
                            r_pending <= r_pending & ~(LANES'(1) << w_emitLane);
                        end else begin
                            r_outValid <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign out_valid    = r_outValid;
    assign out_row      = r_outRow;
    assign out_col      = r_outCol;
    assign out_ch       = r_outCh;
    assign out_lin_addr = r_outLin;
    assign out_lane     = r_outLane;

endmodule

// File: tb/tb_oa_addr_serializer.sv
// Directed plus randomized bench for oa_addr_serializer; the expected element stream
// for each bundle is built as a queue from the lane fields, mask and range rules.
module tb_oa_addr_serializer;

    localparam int LANES   = 8;
    localparam int ROW_W   = 10;
    localparam int COL_W   = 11;
    localparam int CH_W    = 8;
    localparam int OA_ROWS = 64;
    localparam int OA_COLS = 64;
    localparam int LIN_W   = 24;
    localparam int LANE_W  = 3;

    logic                   clock;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*ROW_W-1:0] in_row;
    logic [LANES*COL_W-1:0] in_col;
    logic [LANES*CH_W-1:0]  in_ch;
    logic [LANES-1:0]       in_mask;
    logic                   out_valid;
    logic                   out_ready;
    logic [ROW_W-1:0]       out_row;
    logic [COL_W-1:0]       out_col;
    logic [CH_W-1:0]        out_ch;
    logic [LIN_W-1:0]       out_lin_addr;
    logic [LANE_W-1:0]      out_lane;
    logic                   busy;
    logic [15:0]            drop_count;

    oa_addr_serializer dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_col(in_col), .in_ch(in_ch), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_ch(out_ch),
        .out_lin_addr(out_lin_addr), .out_lane(out_lane),
        .busy(busy), .drop_count(drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [CH_W-1:0]   ch;
        logic [LIN_W-1:0]  lin;
        logic [LANE_W-1:0] lane;
    } elem_t;

    elem_t       expQ[$];
    logic [15:0] expDrop;
    int          tRow [LANES];
    int          tCol [LANES];
    int          tCh  [LANES];
    int          checks = 0;
    int          errors = 0;

    function automatic elem_t observed();
        return {out_row, out_col, out_ch, out_lin_addr, out_lane};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives one bundle at a negedge, builds the expected element queue, returns one cycle later.
    task automatic applyStimulus(input logic [LANES-1:0] mask);
        int     drops;
        bit     inRange;
        longint lin;
        elem_t  e;
        expQ.delete();
        drops = 0;
        for (int i = 0; i < LANES; i++) begin
            in_row[i*ROW_W +: ROW_W] = ROW_W'(tRow[i]);
            in_col[i*COL_W +: COL_W] = COL_W'(tCol[i]);
            in_ch[i*CH_W +: CH_W]    = CH_W'(tCh[i]);
`ifdef OA_BOUNDS_CHECK_EN
            inRange = (tRow[i] < OA_ROWS) && (tCol[i] < OA_COLS);
`else
            inRange = 1'b1;
`endif
            if (mask[i] && inRange) begin
                lin    = ((longint'(tCh[i]) * OA_ROWS + tRow[i]) * OA_COLS + tCol[i]) % (longint'(1) << LIN_W);
                e.row  = ROW_W'(tRow[i]);
                e.col  = COL_W'(tCol[i]);
                e.ch   = CH_W'(tCh[i]);
                e.lin  = lin[LIN_W-1:0];
                e.lane = LANE_W'(i);
                expQ.push_back(e);
            end else if (mask[i]) begin
                drops++;
            end
        end
        expDrop = (int'(expDrop) + drops > 65535) ? 16'hFFFF : 16'(int'(expDrop) + drops);
        in_mask  = mask;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // mode 0: out_ready always high; 1: random; 2: low for the first 5 cycles, then high.
    task automatic checkOutput(input int mode);
        int idx = 0;
        int cyc = 0;
        int n   = expQ.size();
        bit rdy;
        forever begin
            if (idx < n) begin
                check("emitValid", 64'(out_valid), 64'd1);
                check("emitInReady", 64'(in_ready), 64'd0);
                check("emitBusy", 64'(busy), 64'd1);
                check($sformatf("elem%0d", idx), 64'(observed()), 64'(expQ[idx]));
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    default: rdy = (cyc >= 5);
                endcase
                out_ready = rdy;
                // Traffic presented while busy must be ignored.
                in_valid = 1'($urandom_range(0, 1));
                in_mask  = LANES'($urandom());
                in_row   = {in_row[LANES*ROW_W-2:0], in_row[LANES*ROW_W-1]};
                if (rdy) idx++;
                cyc++;
                if (cyc > 200) begin
                    check("timeout", 64'(idx), 64'(n));
                    in_valid = 1'b0;
                    break;
                end
                @(negedge clock);
            end else begin
                check("doneValid", 64'(out_valid), 64'd0);
                check("doneInReady", 64'(in_ready), 64'd1);
                check("doneBusy", 64'(busy), 64'd0);
                check("dropCount", 64'(drop_count), 64'(expDrop));
                in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic setLanes(input int rowMax, input int colMax);
        for (int i = 0; i < LANES; i++) begin
            tRow[i] = int'($urandom_range(0, rowMax));
            tCol[i] = int'($urandom_range(0, colMax));
            tCh[i]  = int'($urandom_range(0, 255));
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_row    = '0;
        in_col    = '0;
        in_ch     = '0;
        in_mask   = '0;
        expDrop   = 16'd0;

        // Reset state
        @(negedge clock);
        check("rstValid", 64'(out_valid), 64'd0);
        check("rstInReady", 64'(in_ready), 64'd1);
        check("rstBusy", 64'(busy), 64'd0);
        check("rstDrop", 64'(drop_count), 64'd0);
        check("rstFields", 64'(observed()), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Sparse mask: lanes 0, 2, 7 back-to-back
        setLanes(63, 63);
        applyStimulus(8'b1000_0101);
        checkOutput(0);

        // Known linear address for lane 0
        setLanes(63, 63);
        tRow[0] = 2; tCol[0] = 3; tCh[0] = 1;
        applyStimulus(8'h01);
        check("lin4227", 64'(out_lin_addr), 64'd4227);
        checkOutput(0);

        // Full bundle with backpressure for 5 cycles
        setLanes(63, 63);
        applyStimulus(8'hFF);
        checkOutput(2);

        // Empty bundle
        setLanes(63, 63);
        applyStimulus(8'h00);
        checkOutput(0);

        // Lane 1 row out of range
        setLanes(63, 63);
        tRow[1] = 64;
        applyStimulus(8'h03);
        checkOutput(0);

        // Maximum field values
        for (int i = 0; i < LANES; i++) begin
            tRow[i] = 63; tCol[i] = 63; tCh[i] = 255;
        end
        applyStimulus(8'h81);
        checkOutput(1);

        // Randomized bundles, some lanes out of range
        for (int b = 0; b < 30; b++) begin
            setLanes(71, 71);
            applyStimulus(LANES'($urandom()));
            checkOutput(1);
        end

        // Reset mid-bundle after the first of 4 elements is accepted
        setLanes(63, 63);
        out_ready = 1'b0;
        applyStimulus(8'h0F);
        check("midElem0", 64'(observed()), 64'(expQ[0]));
        out_ready = 1'b1;
        @(negedge clock);
        check("midElem1", 64'(observed()), 64'(expQ[1]));
        reset = 1'b1;
        #1;
        check("midRstValid", 64'(out_valid), 64'd0);
        check("midRstDrop", 64'(drop_count), 64'd0);
        check("midRstInReady", 64'(in_ready), 64'd1);
        expDrop = 16'd0;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("postRstValid", 64'(out_valid), 64'd0);
            check("postRstBusy", 64'(busy), 64'd0);
        end

        // Normal operation resumes after reset
        setLanes(63, 63);
        applyStimulus(8'b0101_0010);
        checkOutput(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
